// File: rtl/digit_render.sv
// Seven-segment glyph renderer: draws the active digit onto the (vcnt,hcnt) pixel stream.
// Optional auto-stepping of the digit once every CYCLE_FRAMES frames under `DIGIT_CYCLE_EN.
module digit_render #(
  parameter int unsigned X_MIN        = 390,
  parameter int unsigned X_MAX        = 890,
  parameter int unsigned Y_MIN        = 110,
  parameter int unsigned Y_MAX        = 610,
  parameter int unsigned STROKE       = 20,
  parameter int unsigned CYCLE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  vcnt,
  input  logic [10:0] hcnt,
  input  logic [3:0]  number_in,
  input  logic        number_load,
  output logic        Bit,
  output logic        number_ack,
  output logic        number_err,
  output logic [3:0]  digit_cur
);

  localparam int unsigned X_MID = (X_MIN + X_MAX) / 2;
  localparam int unsigned Y_MID = (Y_MIN + Y_MAX) / 2;
  localparam int unsigned HS    = STROKE / 2;

  logic [3:0] active_q, active_d, pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       bit_q, bit_d, ack_q, ack_d, err_q, err_d;
  logic       commit, load_ok;
  logic [31:0] x, y;
  logic       in_x, in_y, y_top, y_bot, x_lft, x_rgt;
  logic [7:0] seg, mask;   // {h,g,f,e,d,c,b,a}

`ifdef DIGIT_CYCLE_EN
  logic [15:0] cnt_q, cnt_d;
  logic        cnt_wrap;
  assign cnt_wrap = ({16'd0, cnt_q} == CYCLE_FRAMES - 1);
`endif

  always_comb begin
    x     = {21'd0, hcnt};
    y     = {22'd0, vcnt};
    in_x  = (x >= X_MIN) && (x < X_MAX);
    in_y  = (y >= Y_MIN) && (y < Y_MAX);
    y_top = (y >= Y_MIN) && (y < Y_MID);
    y_bot = (y >= Y_MID) && (y < Y_MAX);
    x_lft = (x >= X_MIN) && (x < X_MIN + STROKE);
    x_rgt = (x >= X_MAX - STROKE) && (x < X_MAX);
    seg[0] = in_x && (y >= Y_MIN) && (y < Y_MIN + STROKE);
    seg[1] = x_rgt && y_top;
    seg[2] = x_rgt && y_bot;
    seg[3] = in_x && (y >= Y_MAX - STROKE) && (y < Y_MAX);
    seg[4] = x_lft && y_bot;
    seg[5] = x_lft && y_top;
    seg[6] = in_x && (y >= Y_MID - HS) && (y < Y_MID + HS);
    seg[7] = in_y && (x >= X_MID - HS) && (x < X_MID + HS);
  end

  always_comb begin
    mask = 8'h00;
    unique case (active_q)
      4'd0:    mask = 8'b0011_1111;
      4'd1:    mask = 8'b1000_0000;
      4'd2:    mask = 8'b0101_1011;
      4'd3:    mask = 8'b0100_1111;
      4'd4:    mask = 8'b0110_0110;
      4'd5:    mask = 8'b0110_1101;
      4'd6:    mask = 8'b0111_1101;
      4'd7:    mask = 8'b0000_0111;
      4'd8:    mask = 8'b0111_1111;
      4'd9:    mask = 8'b0110_1111;
      default: mask = 8'h00;
    endcase
  end

  always_comb begin
    commit     = (vcnt == 10'd1) && (hcnt == 11'd0);
    load_ok    = number_load && (number_in <= 4'd9);
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    err_d      = number_load && (number_in > 4'd9);
    bit_d      = |(mask & seg);
`ifdef DIGIT_CYCLE_EN
    cnt_d = cnt_q;
    if (commit) cnt_d = cnt_wrap ? 16'd0 : cnt_q + 16'd1;
`endif
    // Commit consumes the pre-cycle pending state, so a same-cycle load waits a frame.
    if (commit && pend_vld_q) begin
      active_d   = pend_q;
      pend_vld_d = 1'b0;
      ack_d      = 1'b1;
    end
`ifdef DIGIT_CYCLE_EN
    else if (commit && cnt_wrap) begin
      active_d = (active_q == 4'd9) ? 4'd0 : active_q + 4'd1;
    end
`endif
    if (load_ok) begin
      pend_d     = number_in;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q   <= 4'd0;
      pend_q     <= 4'd0;
      pend_vld_q <= 1'b0;
      bit_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef DIGIT_CYCLE_EN
      cnt_q      <= 16'd0;
`endif
    end else begin
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bit_q      <= bit_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
`ifdef DIGIT_CYCLE_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign Bit        = bit_q;
  assign number_ack = ack_q;
  assign number_err = err_q;
  assign digit_cur  = active_q;

endmodule

// File: tb/tb_digit_render.sv
// Directed-vector bench for digit_render; auto-step sequence runs when DIGIT_CYCLE_EN is defined.
module tb_digit_render;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  vcnt;
  logic [10:0] hcnt;
  logic [3:0]  number_in;
  logic        number_load;
  logic        Bit, number_ack, number_err;
  logic [3:0]  digit_cur;
  int          errs = 0, checks = 0;

  always #5 clk = ~clk;

  digit_render #(.CYCLE_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .vcnt(vcnt), .hcnt(hcnt),
    .number_in(number_in), .number_load(number_load),
    .Bit(Bit), .number_ack(number_ack), .number_err(number_err),
    .digit_cur(digit_cur)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int px, input int py, input logic exp, input string tag);
    hcnt = 11'(px);
    vcnt = 10'(py);
    tick();
    chk(tag, 32'(Bit), 32'(exp));
    vcnt = 10'd200;
    hcnt = 11'd100;
  endtask

  task automatic load(input logic [3:0] d);
    vcnt = 10'd200;
    hcnt = 11'd500;
    number_in = d;
    number_load = 1'b1;
    tick();
    number_load = 1'b0;
  endtask

  // Commit point then two idle cycles; returns how many ack pulses were seen.
  task automatic commit_frame(output int acks);
    acks = 0;
    vcnt = 10'd1;
    hcnt = 11'd0;
    tick();
    acks += int'(number_ack);
    vcnt = 10'd200;
    hcnt = 11'd500;
    tick();
    acks += int'(number_ack);
    tick();
    acks += int'(number_ack);
  endtask

  initial begin
    int a;
    rst_n = 1'b0; vcnt = 10'd0; hcnt = 11'd0; number_in = 4'd0; number_load = 1'b0;
    tick(); tick();
    chk("rst_bit", 32'(Bit), 32'd0);
    chk("rst_ack", 32'(number_ack), 32'd0);
    chk("rst_err", 32'(number_err), 32'd0);
    chk("rst_digit", 32'(digit_cur), 32'd0);
    rst_n = 1'b1;
`ifdef DIGIT_CYCLE_EN
    for (int n = 1; n <= 20; n++) begin
      commit_frame(a);
      chk("cyc_ack", 32'(a), 32'd0);
      chk("cyc_digit", 32'(digit_cur), 32'((n / 2) % 10));
    end
`else
    // digit 0: abcdef lit, g and h dark
    pix(640, 200, 1'b0, "d0_h");
    pix(395, 200, 1'b1, "d0_f");
    pix(500, 115, 1'b1, "d0_a");
    pix(500, 605, 1'b1, "d0_d");
    pix(500, 360, 1'b0, "d0_g");
    pix(880, 500, 1'b1, "d0_c");
    pix(300, 300, 1'b0, "d0_out");
    pix(890, 115, 1'b0, "d0_xmax");
    pix(889, 115, 1'b1, "d0_xmax_m1");
    pix(500, 109, 1'b0, "d0_ymin_m1");
    // load 8 mid-frame: display unchanged until commit
    load(4'd8);
    chk("l8_noack", 32'(number_ack), 32'd0);
    chk("l8_digit_pre", 32'(digit_cur), 32'd0);
    pix(500, 360, 1'b0, "l8_g_pre");
    vcnt = 10'd1; hcnt = 11'd0;
    tick();
    chk("l8_ack", 32'(number_ack), 32'd1);
    chk("l8_digit", 32'(digit_cur), 32'd8);
    vcnt = 10'd200; hcnt = 11'd500;
    tick();
    chk("l8_ack_end", 32'(number_ack), 32'd0);
    pix(610, 115, 1'b1, "d8_a");
    pix(610, 360, 1'b1, "d8_g");
    pix(610, 600, 1'b1, "d8_d");
    pix(395, 310, 1'b1, "d8_f");
    pix(880, 443, 1'b1, "d8_c");
    pix(640, 200, 1'b0, "d8_h");
    // last load wins, single ack
    load(4'd3);
    load(4'd5);
    commit_frame(a);
    chk("l35_acks", 32'(a), 32'd1);
    chk("l35_digit", 32'(digit_cur), 32'd5);
    // illegal load
    load(4'd12);
    chk("l12_err", 32'(number_err), 32'd1);
    tick();
    chk("l12_err_end", 32'(number_err), 32'd0);
    commit_frame(a);
    chk("l12_acks", 32'(a), 32'd0);
    chk("l12_digit", 32'(digit_cur), 32'd5);
    // reset mid-frame drops the pending load
    load(4'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid_digit", 32'(digit_cur), 32'd0);
    pix(395, 200, 1'b1, "rstmid_f");
    commit_frame(a);
    chk("rstmid_acks", 32'(a), 32'd0);
    chk("rstmid_digit2", 32'(digit_cur), 32'd0);
    // load on the commit cycle stays pending one more frame
    load(4'd7);
    vcnt = 10'd1; hcnt = 11'd0; number_in = 4'd1; number_load = 1'b1;
    tick();
    number_load = 1'b0;
    chk("lc_ack", 32'(number_ack), 32'd1);
    chk("lc_digit", 32'(digit_cur), 32'd7);
    commit_frame(a);
    chk("lc2_acks", 32'(a), 32'd1);
    chk("lc2_digit", 32'(digit_cur), 32'd1);
    pix(640, 200, 1'b1, "d1_h");
    pix(649, 609, 1'b1, "d1_h_corner");
    pix(650, 200, 1'b0, "d1_h_right");
    pix(395, 200, 1'b0, "d1_f");
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
